uart8_rx_fifo: RTL and testbench



---
 rtl/uart8_rx_fifo_pkg.sv | 15 +
 rtl/uart8_rx_fifo_mem.sv | 34 +++
 rtl/uart8_rx_fifo.sv | 142 ++++++++++++++
 tb/tb_uart8_rx_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart8_rx_fifo_pkg.sv
// Shared UART receive-path constants and types.
// Holds the data width, default FIFO depth and receiver state encoding.
package uart8_rx_fifo_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_rx_state_t;

endpackage

// File: rtl/uart8_rx_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_W register array, one write port, one async read port.
// Ports: clk, rstN, i_we, i_waddr, i_wdata, i_raddr, o_rdata.
module sync_fifo_mem
    import uart8_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Cleared on reset so the head byte reads as zero out of reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart8_rx_fifo.sv
// uart8_rx_fifo: turns the UART receiver's level done/rxOut into single FIFO
// pushes and presents bytes over a first-word-fall-through valid/ready port.
// Ports: clk, rstN, en (low = flush), rxDone/rxErr/rxData from receiver,
//        outValid/outData/outReady to host, count/full/empty status,
//        overflow (sticky, cleared by clrOvf), errCount.
// Macro UART_RX_FIFO_ERR_COUNT_EN enables the saturating frame error counter.
module uart8_rx_fifo
    import uart8_rx_fifo_pkg::*;
#(
    parameter  int DEPTH  = UART_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   en,
    input  logic                   rxDone,
    input  logic                   rxErr,
    input  logic [UART_DATA_W-1:0] rxData,
    output logic                   outValid,
    output logic [UART_DATA_W-1:0] outData,
    input  logic                   outReady,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   clrOvf,
    output logic [7:0]             errCount
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic              r_doneQ;
    logic              r_ovf;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_drop;
    logic [UART_DATA_W-1:0] w_rdData;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // One push per frame: only the rising edge of done, and never on an error frame.
    assign w_push   = en & rxDone & ~r_doneQ & ~rxErr;
    assign w_pop    = en & ~w_empty & outReady;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_doneQ <= 1'b0;
        end else if (!en) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_doneQ <= 1'b0;
        end else begin
            r_doneQ <= rxDone;
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A drop in the same cycle as clrOvf keeps the flag set.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clrOvf) begin
            r_ovf <= 1'b0;
        end
    end

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (UART_DATA_W)
    ) u_mem (
        .clk     (clk),
        .rstN    (rstN),
        .i_we    (w_accept),
        .i_waddr (r_wrPtr),
        .i_wdata (rxData),
        .i_raddr (r_rdPtr),
        .o_rdata (w_rdData)
    );

`ifdef UART_RX_FIFO_ERR_COUNT_EN
    logic       r_errQ;
    logic [7:0] r_errCount;
    logic       w_errEvt;

    assign w_errEvt = en & rxErr & ~r_errQ;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_errQ     <= 1'b0;
            r_errCount <= 8'h00;
        end else begin
            r_errQ <= en & rxErr;
            if (clrOvf) begin
                r_errCount <= w_errEvt ? 8'h01 : 8'h00;
            end else if (w_errEvt && r_errCount != 8'hFF) begin
                r_errCount <= r_errCount + 8'h01;
            end
        end
    end

    assign errCount = r_errCount;
`else
    assign errCount = 8'h00;
`endif

    assign outValid = ~w_empty;
    assign outData  = w_rdData;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_uart8_rx_fifo.sv
// Randomized self-checking bench for uart8_rx_fifo.
// A queue-based reference model tracks the expected FIFO contents and flags.
module tb_uart8_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rstN;
    logic       en;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxData;
    logic       outValid;
    logic [7:0] outData;
    logic       outReady;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clrOvf;
    logic [7:0] errCount;

    int checks;
    int errors;

    byte unsigned q[$];
    bit           m_done;
    bit           m_err;
    bit           m_ovf;
    int           m_errc;
    logic [7:0]   dut_last;

    uart8_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .en       (en),
        .rxDone   (rxDone),
        .rxErr    (rxErr),
        .rxData   (rxData),
        .outValid (outValid),
        .outData  (outData),
        .outReady (outReady),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clrOvf   (clrOvf),
        .errCount (errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_errc();
`ifdef UART_RX_FIFO_ERR_COUNT_EN
        return m_errc;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_done = 0;
        m_err  = 0;
        m_ovf  = 0;
        m_errc = 0;
    endtask

    // Applies the spec rules for one clock edge using the inputs held before it.
    task automatic model_edge();
        bit push, pop, drop, evt;
        if (!en) begin
            q.delete();
            m_done = 0;
            m_err  = 0;
            if (clrOvf) begin
                m_ovf  = 0;
                m_errc = 0;
            end
        end else begin
            pop  = (q.size() != 0) && outReady;
            push = rxDone && !m_done && !rxErr;
            evt  = rxErr && !m_err;
            drop = push && (q.size() == DEPTH) && !pop;
            if (pop) void'(q.pop_front());
            if (push && !drop) q.push_back(rxData);
            if (drop) m_ovf = 1;
            else if (clrOvf) m_ovf = 0;
            if (clrOvf) m_errc = evt ? 1 : 0;
            else if (evt && m_errc < 255) m_errc++;
            m_done = rxDone;
            m_err  = rxErr;
        end
    endtask

    task automatic check_all();
        chk("count", count, q.size());
        chk("valid", outValid, q.size() != 0);
        if (q.size() != 0) chk("data", outData, q[0]);
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("ovf", overflow, m_ovf);
        chk("errcnt", errCount, exp_errc());
    endtask

    task automatic step();
        if (en && outValid && outReady) dut_last = outData;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic frame(input logic [7:0] d, input int len);
        rxData = d;
        rxDone = 1'b1;
        repeat (len) step();
        rxDone = 1'b0;
        step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        dut_last = 8'h00;
        model_reset();
        rstN     = 1'b0;
        en       = 1'b0;
        rxDone   = 1'b0;
        rxErr    = 1'b0;
        rxData   = 8'h00;
        outReady = 1'b0;
        clrOvf   = 1'b0;
        #12;
        check_all();
        chk("rst_data", outData, 8'h00);
        rstN = 1'b1;
        en   = 1'b1;
        step();

        // Single long frame: exactly one push, visible one clock after the edge.
        rxData = 8'hA5;
        rxDone = 1'b1;
        step();
        chk("single_valid", outValid, 1'b1);
        chk("single_data", outData, 8'hA5);
        repeat (15) step();
        rxDone = 1'b0;
        step();
        chk("single_count", count, 5'd1);
        outReady = 1'b1;
        step();
        outReady = 1'b0;

        // Burst into a stalled host, then overflow.
        for (int i = 0; i < 16; i++) frame(8'(i), $urandom_range(1, 16));
        frame(8'h55, 4);
        chk("burst_full", full, 1'b1);
        chk("burst_ovf", overflow, 1'b1);
        chk("burst_head", outData, 8'h00);
        outReady = 1'b1;
        repeat (16) step();
        outReady = 1'b0;
        chk("burst_last", dut_last, 8'h0F);
        chk("burst_empty", empty, 1'b1);
        clrOvf = 1'b1;
        step();
        clrOvf = 1'b0;
        chk("clr_ovf", overflow, 1'b0);

        // Full with push and pop in the same cycle.
        for (int i = 0; i < 16; i++) frame(8'(8'h10 + i), 2);
        rxData   = 8'h20;
        rxDone   = 1'b1;
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        chk("pp_count", count, 5'd16);
        chk("pp_ovf", overflow, 1'b0);
        repeat (2) step();
        rxDone   = 1'b0;
        outReady = 1'b1;
        repeat (17) step();
        outReady = 1'b0;
        chk("pp_last", dut_last, 8'h20);

        // Error frame: done rises with err high.
        rxData = 8'h77;
        rxDone = 1'b1;
        rxErr  = 1'b1;
        step();
        chk("err_count0", count, 5'd0);
`ifdef UART_RX_FIFO_ERR_COUNT_EN
        chk("err_cnt", errCount, 8'd1);
`else
        chk("err_cnt", errCount, 8'd0);
`endif
        rxErr = 1'b0;
        step();
        rxDone = 1'b0;
        step();

        // Flush with 5 entries and overflow set.
        for (int i = 0; i < 17; i++) frame(8'(8'h40 + i), 1);
        outReady = 1'b1;
        repeat (11) step();
        outReady = 1'b0;
        chk("fl_pre", count, 5'd5);
        en = 1'b0;
        step();
        en = 1'b1;
        chk("fl_count", count, 5'd0);
        chk("fl_valid", outValid, 1'b0);
        chk("fl_ovf", overflow, 1'b1);
        frame(8'h3C, 3);
        chk("fl_next", outData, 8'h3C);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 30) rxDone = ~rxDone;
            rxErr    = ($urandom_range(0, 99) < 6);
            rxData   = 8'($urandom);
            outReady = ($urandom_range(0, 99) < 35);
            clrOvf   = ($urandom_range(0, 99) < 2);
            en       = ($urandom_range(0, 199) != 0);
            step();
        end

        // Async reset between edges with 3 entries held.
        en       = 1'b0;
        rxDone   = 1'b0;
        rxErr    = 1'b0;
        clrOvf   = 1'b0;
        outReady = 1'b0;
        step();
        en = 1'b1;
        step();
        frame(8'hC1, 2);
        frame(8'hC2, 2);
        frame(8'hC3, 2);
        chk("ar_pre", count, 5'd3);
        #2;
        rstN = 1'b0;
        #1;
        model_reset();
        chk("ar_count", count, 5'd0);
        chk("ar_valid", outValid, 1'b0);
        chk("ar_empty", empty, 1'b1);
        chk("ar_full", full, 1'b0);
        chk("ar_data", outData, 8'h00);
        chk("ar_ovf", overflow, 1'b0);
        chk("ar_errc", errCount, 8'h00);
        #2;
        rstN = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
